// File: rtl/csi_if_seq.sv
// csi_if_seq
// Boot and recovery sequencer for the stereo CSI input block (csi_if).
// It enables both capture channels over the csi_if internal bus, then watches
// sof_in/vin for frame lock. A bad frame or a missing SOF disables and
// re-enables capture, up to MAX_RETRY times, after which it parks in ERROR.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           1-cycle pulse, honoured only in IDLE and ERROR
//   ibus_cs/wr      bus chip select / write strobe to csi_if
//   ibus_addr       bus address (holds last value)
//   ibus_wrdata     bus write data (holds last value)
//   ibus_rddata     bus read data (readback build only)
//   sof_in, vin     csi_if sof_out / vout
//   busy            high in every state except IDLE, LOCKED, ERROR
//   locked, err     high only in LOCKED / ERROR
//   retry_cnt       recoveries performed since start
//   frame_cnt       good frames seen while LOCKED (wraps)
//
// Optional feature macro: CSI_IF_SEQ_READBACK_EN
//   defined   - after the enable gap the control register is read back
//               (cs held 5 cycles, sampled on the 5th, then WR_GAP idle);
//               a mismatch triggers recovery
//   undefined - no read, GAP goes straight to ACQ
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | after reset, waiting for start
// EN_WR   | bus write of CTRL_VAL to CTRL_ADDR
// GAP     | WR_GAP idle cycles after the enable write
// RD      | readback access, cs held 5 cycles (readback build only)
// RD_GAP  | WR_GAP idle cycles after the readback (readback build only)
// ACQ     | waiting for the first SOF, which arms the pixel counter
// CHECK   | comparing each frame's pixel count, counting good frames
// LOCKED  | locked; still checking every frame
// RECOVER | retry limit check; bus write of 0 when retrying
// RGAP    | WR_GAP idle cycles after the disable write
// ERROR   | retries exhausted, waiting for start
module csi_if_seq #(
    parameter logic [7:0]  CTRL_ADDR   = 8'h00,
    parameter logic [31:0] CTRL_VAL    = 32'h0000_0003,
    parameter logic [31:0] EXP_PIX     = 32'd307200,
    parameter int          LOCK_FRAMES = 4,
    parameter logic [31:0] TO_CYCLES   = 32'd4000000,
    parameter int          MAX_RETRY   = 3,
    parameter int          WR_GAP      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        ibus_cs,
    output logic        ibus_wr,
    output logic [7:0]  ibus_addr,
    output logic [31:0] ibus_wrdata,
    input  logic [31:0] ibus_rddata,
    input  logic        sof_in,
    input  logic        vin,
    output logic        busy,
    output logic        locked,
    output logic        err,
    output logic [3:0]  retry_cnt,
    output logic [15:0] frame_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_EN_WR, S_GAP, S_RD, S_RD_GAP, S_ACQ,
        S_CHECK, S_LOCKED, S_RECOVER, S_RGAP, S_ERROR
    } state_t;

    localparam logic [15:0] GAP_LD  = 16'(WR_GAP - 1);
    localparam logic [15:0] RD_LD   = 16'd4;
    localparam logic [31:0] TO_LD   = TO_CYCLES - 32'd1;
    localparam logic [15:0] LOCK_W  = 16'(LOCK_FRAMES);
    localparam logic [3:0]  RETRY_W = 4'(MAX_RETRY);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_wait;
    logic [31:0] r_to;
    logic [31:0] r_pix;
    logic [15:0] r_good;
    logic [3:0]  r_retry;
    logic [15:0] r_frame;
    logic [7:0]  r_addr;
    logic [31:0] r_wrdata;

    logic w_mon, w_sof, w_tout, w_pix_ok, w_wait_done;
    logic w_retry_max, w_lock_hit, w_start_ok;

`ifdef CSI_IF_SEQ_READBACK_EN
    logic r_rd_ok;
`else
    logic w_unused_rddata;
    assign w_unused_rddata = ^ibus_rddata;
`endif

    assign w_mon       = (r_state == S_ACQ) || (r_state == S_CHECK) || (r_state == S_LOCKED);
    assign w_sof       = w_mon && sof_in;
    // SOF in the terminal cycle wins over the timeout
    assign w_tout      = w_mon && !sof_in && (r_to == '0);
    assign w_pix_ok    = (r_pix == EXP_PIX);
    assign w_wait_done = (r_wait == '0);
    assign w_retry_max = (r_retry == RETRY_W);
    assign w_lock_hit  = (16'(r_good + 16'd1) == LOCK_W);
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_ERROR));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_ERROR: if (start) w_next = S_EN_WR;
            S_EN_WR:         w_next = S_GAP;
`ifdef CSI_IF_SEQ_READBACK_EN
            S_GAP:           if (w_wait_done) w_next = S_RD;
            S_RD:            if (w_wait_done) w_next = S_RD_GAP;
            S_RD_GAP:        if (w_wait_done) w_next = r_rd_ok ? S_ACQ : S_RECOVER;
`else
            S_GAP:           if (w_wait_done) w_next = S_ACQ;
`endif
            S_ACQ: begin
                if (w_sof)       w_next = S_CHECK;
                else if (w_tout) w_next = S_RECOVER;
            end
            S_CHECK: begin
                if (w_sof)       w_next = !w_pix_ok ? S_RECOVER : (w_lock_hit ? S_LOCKED : S_CHECK);
                else if (w_tout) w_next = S_RECOVER;
            end
            S_LOCKED: begin
                if (w_sof && !w_pix_ok) w_next = S_RECOVER;
                else if (w_tout)        w_next = S_RECOVER;
            end
            S_RECOVER:       w_next = w_retry_max ? S_ERROR : S_RGAP;
            S_RGAP:          if (w_wait_done) w_next = S_EN_WR;
            default:         w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ibus_cs = 1'b0;
        ibus_wr = 1'b0;
        if ((r_state == S_EN_WR) || ((r_state == S_RECOVER) && !w_retry_max)) begin
            ibus_cs = 1'b1;
            ibus_wr = 1'b1;
        end
        if (r_state == S_RD) ibus_cs = 1'b1;
        busy   = !((r_state == S_IDLE) || (r_state == S_LOCKED) || (r_state == S_ERROR));
        locked = (r_state == S_LOCKED);
        err    = (r_state == S_ERROR);
    end

    assign ibus_addr   = r_addr;
    assign ibus_wrdata = r_wrdata;
    assign retry_cnt   = r_retry;
    assign frame_cnt   = r_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait   <= '0;
            r_to     <= '0;
            r_pix    <= '0;
            r_good   <= '0;
            r_retry  <= '0;
            r_frame  <= '0;
            r_addr   <= '0;
            r_wrdata <= '0;
        end else begin
            // wait timer is loaded on every state change, only the wait states look at it
            if (w_next != r_state)   r_wait <= (w_next == S_RD) ? RD_LD : GAP_LD;
            else if (!w_wait_done)   r_wait <= r_wait - 16'd1;

            if (!w_mon || sof_in)    r_to <= TO_LD;
            else if (r_to != '0)     r_to <= r_to - 32'd1;

            // the SOF cycle is the first pixel of the new frame
            if (!w_mon)                       r_pix <= '0;
            else if (sof_in)                  r_pix <= 32'd1;
            else if (vin && (r_pix != '1))    r_pix <= r_pix + 32'd1;

            if (w_start_ok) begin
                r_retry <= '0;
                r_good  <= '0;
                r_frame <= '0;
            end else begin
                if ((r_state == S_RECOVER) && !w_retry_max) r_retry <= r_retry + 4'd1;
                if (w_next == S_RECOVER)                            r_good <= '0;
                else if ((r_state == S_CHECK) && w_sof && w_pix_ok) r_good <= r_good + 16'd1;
                if ((r_state == S_LOCKED) && w_sof && w_pix_ok)     r_frame <= r_frame + 16'd1;
            end

            // address/data are set up one edge ahead so they are valid with cs
            if (w_next == S_EN_WR) begin
                r_addr   <= CTRL_ADDR;
                r_wrdata <= CTRL_VAL;
            end else if ((w_next == S_RECOVER) && !w_retry_max) begin
                r_addr   <= CTRL_ADDR;
                r_wrdata <= '0;
            end
`ifdef CSI_IF_SEQ_READBACK_EN
            else if (w_next == S_RD) begin
                r_addr <= CTRL_ADDR;
            end
`endif
        end
    end

`ifdef CSI_IF_SEQ_READBACK_EN
    always_ff @(posedge clk) begin
        if (rst)                                r_rd_ok <= 1'b0;
        else if ((r_state == S_RD) && w_wait_done) r_rd_ok <= (ibus_rddata == CTRL_VAL);
    end
`endif

endmodule

// File: tb/tb_csi_if_seq.sv
module tb_csi_if_seq;

    localparam int EXP  = 16;
    localparam int LOCK = 2;
    localparam int TO   = 100;
    localparam int GAP  = 5;
`ifdef CSI_IF_SEQ_READBACK_EN
    localparam int T_ACQ = 1 + GAP + 5 + GAP;
`else
    localparam int T_ACQ = 1 + GAP;
`endif

    logic        clk, rst, start, sof_in, vin;
    logic        ibus_cs, ibus_wr, busy, locked, err;
    logic [7:0]  ibus_addr;
    logic [31:0] ibus_wrdata, ibus_rddata;
    logic [3:0]  retry_cnt;
    logic [15:0] frame_cnt;

    csi_if_seq #(
        .CTRL_ADDR(8'h00), .CTRL_VAL(32'h3), .EXP_PIX(32'd16), .LOCK_FRAMES(2),
        .TO_CYCLES(32'd100), .MAX_RETRY(2), .WR_GAP(5)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .ibus_cs(ibus_cs), .ibus_wr(ibus_wr), .ibus_addr(ibus_addr),
        .ibus_wrdata(ibus_wrdata), .ibus_rddata(ibus_rddata),
        .sof_in(sof_in), .vin(vin), .busy(busy), .locked(locked), .err(err),
        .retry_cnt(retry_cnt), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // bus monitor
    int wr_addr[$], wr_data[$], wr_cyc[$], rd_cyc[$];
    int cs_cnt = 0;
    always @(negedge clk) begin
        if (ibus_cs) cs_cnt <= cs_cnt + 1;
        if (ibus_cs && ibus_wr) begin
            wr_addr.push_back(int'(ibus_addr));
            wr_data.push_back(int'(ibus_wrdata));
            wr_cyc.push_back(cyc);
        end
        if (ibus_cs && !ibus_wr) rd_cyc.push_back(cyc);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof_edge();
        sof_in = 1'b1; vin = 1'b1;
        tick();
        sof_in = 1'b0; vin = 1'b0;
    endtask

    // need pixels scattered randomly over slots cycles
    task automatic body(input int need, input int slots);
        int left = need;
        for (int s = slots; s > 0; s--) begin
            if (left == s)      vin = 1'b1;
            else if (left == 0) vin = 1'b0;
            else                vin = 1'($urandom_range(0, 1));
            if (vin) left--;
            tick();
        end
        vin = 1'b0;
    endtask

    // frame-level reference: first SOF arms, later SOFs judge the frame just ended
    bit m_armed, m_lock;
    int m_good, m_frames, m_retry;

    task automatic model_enable();
        m_armed = 1'b0; m_lock = 1'b0; m_good = 0;
    endtask

    function automatic bit model_sof(input int pix);
        if (!m_armed) begin
            m_armed = 1'b1;
            return 1'b0;
        end
        if (pix != EXP) begin
            m_armed = 1'b0; m_lock = 1'b0; m_good = 0;
            return 1'b1;
        end
        if (m_lock) m_frames = (m_frames + 1) % 65536;
        else begin
            m_good++;
            if (m_good >= LOCK) m_lock = 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk_all_zero(input string p);
        chk({p, "_cs"}, ibus_cs, 0);
        chk({p, "_wr"}, ibus_wr, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_locked"}, locked, 0);
        chk({p, "_err"}, err, 0);
        chk({p, "_retry"}, retry_cnt, 0);
        chk({p, "_frame"}, frame_cnt, 0);
        chk({p, "_addr"}, ibus_addr, 0);
        chk({p, "_wrdata"}, ibus_wrdata, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int per, nfr, prev, t0, base, nw, nc, off;
        bit rec, got;
        rst = 1'b1; start = 1'b0; sof_in = 1'b0; vin = 1'b0; ibus_rddata = 32'h3;
        m_frames = 0; m_retry = 0;
        model_enable();

        // reset state
        repeat (3) tick();
        chk_all_zero("rst");
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // power-up and lock
        per = $urandom_range(30, 60);
        start = 1'b1; tick(); start = 1'b0;
        t0 = cyc;
        chk("en_cs", ibus_cs, 1);
        chk("en_wr", ibus_wr, 1);
        chk("en_addr", ibus_addr, 0);
        chk("en_data", ibus_wrdata, 3);
        chk("en_busy", busy, 1);
        tick();
        chk("en_cs_drop", ibus_cs, 0);
        repeat (18) tick();
        start = 1'b1; tick(); start = 1'b0;   // ignored in ACQ
        tick();
        chk("acq_start_nwr", wr_data.size(), 1);
        chk("acq_busy", busy, 1);
        prev = 0;
        nfr = 3 + $urandom_range(2, 5);
        for (int f = 0; f < nfr; f++) begin
            sof_edge();
            rec = model_sof(prev);
            chk("s1_locked", locked, m_lock);
            chk("s1_frames", frame_cnt, m_frames);
            chk("s1_busy", busy, !m_lock);
            if (f == 4) begin
                start = 1'b1; vin = 1'b1; tick(); start = 1'b0; vin = 1'b0;   // ignored in LOCKED
                chk("lock_start_locked", locked, 1);
                body(EXP - 2, per - 2);
            end else begin
                body(EXP - 1, per - 1);
            end
            prev = EXP;
        end
        chk("s1_nwr", wr_data.size(), 1);
        chk("s1_wr_addr", wr_addr[0], 0);
        chk("s1_wr_data", wr_data[0], 3);

        // bad frame while locked
        sof_edge();
        rec = model_sof(prev);
        chk("s2_pre_frames", frame_cnt, m_frames);
        body(EXP - 2, per - 1);
        prev = EXP - 1;
        sof_edge();
        rec = model_sof(prev);
        if (rec) m_retry++;
        chk("s2_locked_drop", locked, m_lock);
        chk("s2_dis_cs", ibus_cs, 1);
        chk("s2_dis_wr", ibus_wr, 1);
        chk("s2_dis_data", ibus_wrdata, 0);
        chk("s2_busy", busy, 1);
        vin = 1'b1; tick(); vin = 1'b0;
        chk("s2_retry", retry_cnt, m_retry);
        chk("s2_gap_cs", ibus_cs, 0);
        body(EXP - 2, per - 2);
        prev = EXP;
        for (int f = 0; f < 3; f++) begin
            sof_edge();
            rec = model_sof(prev);
            chk("s2_relock", locked, m_lock);
            chk("s2_frames", frame_cnt, m_frames);
            body(EXP - 1, per - 1);
        end
        chk("s2_nwr", wr_data.size(), 3);
        if (wr_data.size() >= 3) begin
            chk("s2_wr1_data", wr_data[1], 0);
            chk("s2_wr2_data", wr_data[2], 3);
            chk("s2_wr_sep", wr_cyc[2] - wr_cyc[1], 1 + GAP);
        end
        chk("s2_retry_end", retry_cnt, m_retry);

        // reset from locked, then reset during EN_WR
        rst = 1'b1; tick(); rst = 1'b0;
        chk_all_zero("rst2");
        tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("s4_en_cs", ibus_cs, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("s4_cs", ibus_cs, 0);
        chk("s4_wr", ibus_wr, 0);
        chk("s4_busy", busy, 0);
        chk("s4_wrdata", ibus_wrdata, 0);
        nw = wr_data.size();
        nc = cs_cnt;
        for (int i = 0; i < 30; i++) begin
            sof_in = (i % 10 == 0);
            vin = 1'($urandom_range(0, 1));
            tick();
        end
        sof_in = 1'b0; vin = 1'b0;
        chk("s4_no_wr", wr_data.size(), nw);
        chk("s4_no_cs", cs_cnt, nc);
        chk("s4_idle_busy", busy, 0);

        // no SOF at all: timeouts, retries, error
        base = wr_data.size();
        start = 1'b1; tick(); start = 1'b0;
        t0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            tick();
            if (err) got = 1'b1;
        end
        chk("s3_err_reached", got, 1);
        chk("s3_err_time", cyc - t0, 3 * (T_ACQ + TO) + 2 * (1 + GAP) + 1);
        chk("s3_nwr", wr_data.size() - base, 5);
        off = 0;
        for (int k = 0; k < 5; k++) begin
            if (base + k < wr_data.size()) begin
                chk("s3_wr_data", wr_data[base + k], (k % 2 == 0) ? 3 : 0);
                chk("s3_wr_cyc", wr_cyc[base + k] - t0, off);
            end
            off += (k % 2 == 0) ? (T_ACQ + TO) : (1 + GAP);
        end
        chk("s3_busy", busy, 0);
        chk("s3_retry", retry_cnt, 2);
        chk("s3_locked", locked, 0);
        nw = wr_data.size();
        for (int i = 0; i < 12; i++) begin
            sof_in = (i % 4 == 0); vin = sof_in;
            tick();
        end
        sof_in = 1'b0; vin = 1'b0;
        chk("s3_hold_nwr", wr_data.size(), nw);
        chk("s3_hold_err", err, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("s3_restart_retry", retry_cnt, 0);
        chk("s3_restart_err", err, 0);
        chk("s3_restart_cs", ibus_cs, 1);
        chk("s3_restart_data", ibus_wrdata, 3);

`ifdef CSI_IF_SEQ_READBACK_EN
        // readback mismatch then match
        rst = 1'b1; tick(); rst = 1'b0; tick();
        ibus_rddata = 32'h0;
        base = wr_data.size();
        nc = rd_cyc.size();
        start = 1'b1; tick(); start = 1'b0;
        t0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            if (wr_data.size() >= base + 2) got = 1'b1;
        end
        ibus_rddata = 32'h3;
        chk("s6_recover_wr", got, 1);
        chk("s6_rd_len", rd_cyc.size() - nc, 5);
        if (rd_cyc.size() > nc) chk("s6_rd_first", rd_cyc[nc] - t0, 1 + GAP);
        if (got) begin
            chk("s6_dis_data", wr_data[base + 1], 0);
            chk("s6_dis_cyc", wr_cyc[base + 1] - t0, 1 + GAP + 5 + GAP);
        end
        for (int i = 0; i < 200 && cyc < t0 + 40; i++) tick();
        model_enable();
        m_frames = 0; m_retry = 1;
        prev = 0;
        for (int f = 0; f < 3; f++) begin
            sof_edge();
            rec = model_sof(prev);
            chk("s6_locked", locked, m_lock);
            body(EXP - 1, 39);
            prev = EXP;
        end
        chk("s6_retry", retry_cnt, m_retry);
        chk("s6_rd_total", rd_cyc.size() - nc, 10);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
